// File: rtl/rv_periph_pkg.sv
// Shared definitions for rv32 data-bus peripherals: window base, timer register
// offsets, CTRL field positions and a byte-lane write helper.
package rv_periph_pkg;

  localparam logic [31:0] TMR_BASE  = 32'hffff_0060;

  localparam logic [4:0]  TMR_CTRL  = 5'h00;
  localparam logic [4:0]  TMR_STAT  = 5'h04;
  localparam logic [4:0]  TMR_COUNT = 5'h08;
  localparam logic [4:0]  TMR_CMP   = 5'h0c;
  localparam logic [4:0]  TMR_CYCLO = 5'h10;
  localparam logic [4:0]  TMR_CYCHI = 5'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_PRESC = 8;

  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = wdat[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rv_prescaler.sv
// Programmable divider: counts 0..presc while enabled and emits a one-cycle tick
// on the terminal count. Shared with the serial baud generator.
module rv_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         xreset,
  input  logic         en,
  input  logic         restart,
  input  logic [W-1:0] presc,
  output logic         tick
);

  logic [W-1:0] pcnt;

  assign tick = en & (pcnt == presc);

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset)                    pcnt <= '0;
    else if (!en || restart || tick) pcnt <= '0;
    else                            pcnt <= pcnt + W'(1);
  end

endmodule

// File: rtl/rv_timer.sv
// Compare timer with level irq plus free-running cycle counter, mapped into a
// 32-byte window on the rv32 data bus. dr is zero whenever not driving a read.
module rv_timer
  import rv_periph_pkg::*;
#(
  parameter int PRESC_W = 8,
  parameter int CYC_W   = 64
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic        irq
);

  localparam logic [31:0] CTRL_MASK =
    32'h7 | (((32'd1 << PRESC_W) - 32'd1) << CTRL_PRESC);

  logic [4:0]       off;
  logic             wr_stb, rd_stb;
  logic             wr_ctrl, wr_count, wr_cmp, stat_clr;
  logic [31:0]      ctrl_q, ctrl_d, count_q, cmp_q, snap_q, cyc_hi, rdata;
  logic [CYC_W-1:0] cyc_q;
  logic             match_q, tick, hit, restart;
  logic             unused_adr;

  assign off        = {adr[4:2], 2'b00};
  assign unused_adr = ^adr[1:0];

  assign wr_stb   = cs & rdy & (|we);
  assign rd_stb   = cs & re & rdy;
  assign wr_ctrl  = wr_stb & (off == TMR_CTRL);
  assign wr_count = wr_stb & (off == TMR_COUNT);
  assign wr_cmp   = wr_stb & (off == TMR_CMP);
  assign stat_clr = wr_stb & (off == TMR_STAT) & we[0] & dw[0];

  assign ctrl_d  = lane_merge(ctrl_q, dw, we) & CTRL_MASK;
  assign restart = wr_ctrl & ctrl_d[CTRL_EN] & ~ctrl_q[CTRL_EN];
  assign hit     = tick & (count_q == cmp_q);

  rv_prescaler #(.W(PRESC_W)) u_presc (
    .clk    (clk),
    .xreset (xreset),
    .en     (ctrl_q[CTRL_EN]),
    .restart(restart),
    .presc  (ctrl_q[CTRL_PRESC +: PRESC_W]),
    .tick   (tick)
  );

  // A bus write to COUNT overrides the tick and suppresses that cycle's match.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= ctrl_d;
      if (wr_cmp)  cmp_q  <= lane_merge(cmp_q, dw, we);
      if (wr_count)
        count_q <= lane_merge(count_q, dw, we);
      else if (tick)
        count_q <= (hit & ctrl_q[CTRL_AR]) ? 32'd0 : count_q + 32'd1;
      match_q <= (hit & ~wr_count) | (match_q & ~stat_clr);
      irq     <= match_q & ctrl_q[CTRL_IE];
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      cyc_q  <= '0;
      snap_q <= '0;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      if (rd_stb && off == TMR_CYCLO) snap_q <= cyc_hi;
    end
  end

  generate
    if (CYC_W > 32) begin : g_cyc_hi
      assign cyc_hi = 32'(cyc_q[CYC_W-1:32]);
    end else begin : g_cyc_lo_only
      assign cyc_hi = '0;
    end
  endgenerate

  always_comb begin
    rdata = '0;
    case (off)
      TMR_CTRL:  rdata = ctrl_q;
      TMR_STAT:  rdata = {31'd0, match_q};
      TMR_COUNT: rdata = count_q;
      TMR_CMP:   rdata = cmp_q;
      TMR_CYCLO: rdata = cyc_q[31:0];
      TMR_CYCHI: rdata = snap_q;
      default:   rdata = '0;
    endcase
  end

  // dr holds through a stalled bus cycle and returns to zero after a read.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset)  dr <= '0;
    else if (rdy) dr <= rd_stb ? rdata : 32'd0;
  end

endmodule

// File: tb/tb_rv_timer.sv
// Randomized + directed bench for rv_timer against a phase-based behavioural model.
module tb_rv_timer;
  import rv_periph_pkg::*;

  logic        clk = 1'b0;
  logic        xreset = 1'b1;
  logic [4:0]  adr;
  logic        cs, rdy, re;
  logic [3:0]  we;
  logic [31:0] dw, dr;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_timer #(.PRESC_W(8), .CYC_W(64)) dut (
    .clk   (clk),
    .xreset(xreset),
    .adr   (adr),
    .cs    (cs),
    .rdy   (rdy),
    .we    (we),
    .re    (re),
    .dw    (dw),
    .dr    (dr),
    .irq   (irq)
  );

  // model state: prescaler expressed as cycles elapsed since enable
  logic [31:0] m_ctrl, m_count, m_cmp, m_dr, m_snap;
  logic        m_match, m_irq;
  logic [63:0] m_cyc;
  int unsigned m_since;

  task automatic tb_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_count = 0; m_cmp = 0; m_dr = 0; m_snap = 0;
    m_match = 0; m_irq = 0; m_cyc = 0; m_since = 0;
  endtask

  task automatic model_step();
    logic        wr, rd, tk, hit, clr;
    logic [31:0] rv, nctrl;
    logic [4:0]  off;
    int unsigned pp;
    off = {adr[4:2], 2'b00};
    wr  = cs && rdy && (we != 0);
    rd  = cs && re && rdy;
    pp  = m_ctrl[15:8];
    tk  = m_ctrl[0] && ((m_since % (pp + 1)) == pp);
    case (off)
      5'h00:   rv = m_ctrl;
      5'h04:   rv = {31'd0, m_match};
      5'h08:   rv = m_count;
      5'h0c:   rv = m_cmp;
      5'h10:   rv = m_cyc[31:0];
      5'h14:   rv = m_snap;
      default: rv = 0;
    endcase
    if (rdy) m_dr = rd ? rv : 32'd0;
    m_irq = m_match && m_ctrl[2];
    hit = tk && (m_count == m_cmp) && !(wr && off == 5'h08);
    clr = wr && off == 5'h04 && we[0] && dw[0];
    if (wr && off == 5'h08) m_count = tb_merge(m_count, dw, we);
    else if (tk) m_count = (m_count == m_cmp && m_ctrl[1]) ? 32'd0 : m_count + 1;
    m_match = hit || (m_match && !clr);
    if (wr && off == 5'h0c) m_cmp = tb_merge(m_cmp, dw, we);
    if (rd && off == 5'h10) m_snap = m_cyc[63:32];
    m_cyc = m_cyc + 1;
    if (m_ctrl[0]) m_since++;
    if (wr && off == 5'h00) begin
      nctrl = tb_merge(m_ctrl, dw, we) & 32'h0000_ff07;
      if (!nctrl[0] || !m_ctrl[0]) m_since = 0;
      m_ctrl = nctrl;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    tb_check("dr", dr, m_dr);
    tb_check("irq", irq, m_irq);
  endtask

  task automatic bus_idle();
    cs = 0; re = 0; we = 0; rdy = 1; adr = 0; dw = 0;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    cs = 1; re = 0; we = be; adr = a; dw = d; rdy = 1;
    step();
    bus_idle();
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    cs = 1; re = 1; we = 0; adr = a; rdy = 1;
    step();
    d = dr;
    bus_idle();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v, c;
    int k, r;
    bus_idle();
    model_reset();
    #2 xreset = 1'b0;
    #1;
    tb_check("rst_dr", dr, 0);
    tb_check("rst_irq", irq, 0);
    #9 xreset = 1'b1;

    // basic period, autoreload, irq latency and W1C
    bus_wr(TMR_CMP, 32'd4, 4'hf);
    bus_wr(TMR_CTRL, 32'h7, 4'hf);
    k = 0;
    while (irq !== 1'b1 && k < 20) begin step(); k++; end
    tb_check("irq_latency", k, 6);
    bus_rd(TMR_STAT, v);
    tb_check("match_set", v, 1);
    bus_wr(TMR_CTRL, 32'h4, 4'hf);
    bus_wr(TMR_STAT, 32'h1, 4'h1);
    tb_check("irq_hold_w1c", irq, 1);
    step();
    tb_check("irq_drop", irq, 0);
    bus_rd(TMR_STAT, v);
    tb_check("match_clr", v, 0);

    // asynchronous reset mid-run
    bus_wr(TMR_CTRL, 32'h7, 4'hf);
    idle_n(8);
    bus_rd(TMR_CTRL, v);
    tb_check("ctrl_rb", v, 32'h7);
    #2 xreset = 1'b0;
    #1;
    tb_check("midrst_dr", dr, 0);
    tb_check("midrst_irq", irq, 0);
    model_reset();
    @(posedge clk);
    #3 xreset = 1'b1;
    bus_rd(TMR_STAT, v);
    tb_check("midrst_stat", v, 0);
    bus_rd(TMR_COUNT, v);
    tb_check("midrst_count", v, 0);
    bus_rd(TMR_CYCLO, v);
    tb_check("midrst_cyc", v, 2);

    // prescale by 4
    bus_wr(TMR_CTRL, 32'h0, 4'hf);
    bus_wr(TMR_COUNT, 32'h0, 4'hf);
    bus_wr(TMR_CMP, 32'hffff_ffff, 4'hf);
    bus_wr(TMR_CTRL, 32'h301, 4'hf);
    idle_n(40);
    bus_rd(TMR_COUNT, v);
    tb_check("presc_count", (v >= 9 && v <= 11), 1);

    // byte lanes
    bus_wr(TMR_CTRL, 32'h0, 4'hf);
    bus_wr(TMR_COUNT, 32'h1122_3344, 4'hf);
    bus_wr(TMR_COUNT, 32'hffab_ffff, 4'b0100);
    bus_rd(TMR_COUNT, v);
    tb_check("lane_count", v, 32'h11ab_3344);
    bus_wr(TMR_CMP, 32'hdead_beef, 4'b1001);
    bus_rd(TMR_CMP, v);
    tb_check("lane_cmp", v, 32'hdeff_ffef);

    // W1C colliding with a match: set wins
    bus_wr(TMR_STAT, 32'h1, 4'h1);
    bus_wr(TMR_COUNT, 32'h0, 4'hf);
    bus_wr(TMR_CMP, 32'h3, 4'hf);
    bus_wr(TMR_CTRL, 32'h5, 4'hf);
    idle_n(3);
    bus_wr(TMR_STAT, 32'h1, 4'h1);
    bus_rd(TMR_STAT, v);
    tb_check("w1c_vs_set", v, 1);

    // COUNT write on a tick cycle wins
    bus_wr(TMR_COUNT, 32'h100, 4'hf);
    bus_rd(TMR_COUNT, v);
    tb_check("count_wr_tick", v, 32'h100);

    // rdy low blocks writes and holds dr
    bus_wr(TMR_CTRL, 32'h0, 4'hf);
    bus_wr(TMR_COUNT, 32'h55, 4'hf);
    bus_rd(TMR_CMP, v);
    cs = 1; re = 1; we = 4'hf; adr = TMR_COUNT; dw = 32'hdead; rdy = 0;
    step();
    tb_check("rdy_dr_hold", dr, 32'h3);
    bus_idle();
    bus_rd(TMR_COUNT, v);
    tb_check("rdy_no_write", v, 32'h55);

    // re without cs leaves the bus at zero
    cs = 0; re = 1; adr = TMR_COUNT;
    step();
    tb_check("no_cs_dr", dr, 0);
    bus_idle();

    // CYC_HI returns the snapshot across a 2^32 crossing
    force dut.cyc_q = 64'h0000_0002_ffff_fffe;
    #1;
    release dut.cyc_q;
    m_cyc = 64'h0000_0002_ffff_fffe;
    bus_rd(TMR_CYCLO, v);
    tb_check("cyc_lo", v, 32'hffff_fffe);
    idle_n(3);
    bus_rd(TMR_CYCHI, v);
    tb_check("cyc_hi_snap", v, 32'h2);
    bus_rd(TMR_CYCLO, v);
    bus_rd(TMR_CYCHI, v);
    tb_check("cyc_hi_new", v, 32'h3);

    // randomized traffic
    for (int ep = 0; ep < 6; ep++) begin
      bus_wr(TMR_CTRL, 32'h0, 4'hf);
      bus_wr(TMR_COUNT, 32'h0, 4'hf);
      bus_wr(TMR_CMP, 32'($urandom_range(0, 12)), 4'hf);
      c = 32'h1;
      c[1] = 1'($urandom);
      c[2] = 1'($urandom);
      c[15:8] = 8'($urandom_range(0, 3));
      bus_wr(TMR_CTRL, c, 4'hf);
      for (int i = 0; i < 80; i++) begin
        r   = $urandom_range(0, 9);
        cs  = 1; re = 0; we = 0;
        rdy = ($urandom_range(0, 5) != 0);
        dw  = $urandom;
        adr = 5'($urandom_range(0, 7) << 2);
        case (r)
          0, 1, 2: begin cs = 0; re = 1'($urandom); end
          3, 4, 5: re = 1;
          6: begin adr = TMR_COUNT; we = 4'($urandom); dw = 32'($urandom_range(0, 20)); end
          7: begin adr = TMR_CMP; we = 4'($urandom); dw = 32'($urandom_range(0, 20)); end
          8: begin adr = TMR_STAT; we = 4'($urandom_range(1, 15)); re = 1'($urandom); end
          default: begin adr = TMR_CTRL; we = 4'h1; dw = {29'd0, 2'($urandom), 1'b1}; end
        endcase
        step();
      end
      bus_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
